sp_ram_banked_ctrl: RTL and testbench

- Parametrised successor to the fixed 16 x 2048x8 single-port RAM wrapper.
- Builds a DATA_WIDTH-wide single-port memory from NUM_GROUPS groups of byte-wide ST_SPHDL_*x8 macros.
- Adds a req/gnt/rvalid handshake, a hardware zero-clear sequencer after reset or on demand, and registered read-lane steering.
- Sits between the core_region memory mux and the SRAM macros for instruction and data memory.

---
 rtl/sp_ram_banked_ctrl.sv | 109 ++++++++++
 tb/tb_sp_ram_banked_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/sp_ram_banked_ctrl.sv
// sp_ram_banked_ctrl: banked byte-wide single-port RAM with req/gnt/rvalid handshake and zero-clear sequencer.
// Define RAM_ADDR_CHECK_EN to flag out-of-range groups on err_o instead of aliasing them.
module sp_ram_banked_ctrl #(
   parameter int RAM_SIZE    = 32768,
   parameter int DATA_WIDTH  = 32,
   parameter int MACRO_DEPTH = 2048,
   parameter int ADDR_WIDTH  = $clog2(RAM_SIZE)
) (
   input  logic                    clk,
   input  logic                    rst_i,
   input  logic                    req_i,
   output logic                    gnt_o,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic                    we_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   output logic                    rvalid_o,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   input  logic                    init_i,
   output logic                    init_done_o,
   input  logic                    bypass_en_i,
   output logic                    err_o
);
   localparam int NUM_LANES  = DATA_WIDTH / 8;
   localparam int NUM_GROUPS = RAM_SIZE / (NUM_LANES * MACRO_DEPTH);
   localparam int WA         = $clog2(MACRO_DEPTH);
   localparam int OFS        = $clog2(NUM_LANES);
   localparam int GW         = (ADDR_WIDTH > OFS + WA) ? ADDR_WIDTH - OFS - WA : 1;

   typedef enum logic [1:0] {RST, CLEAR, READY} state_t;

   state_t                             state;
   logic [WA-1:0]                      clr_cnt;
   logic [GW-1:0]                      grp_raw, grp;
   logic                               grp_ok, clearing, mac_we;
   logic [WA-1:0]                      mac_a;
   logic [DATA_WIDTH-1:0]              mac_d, rd_mux;
   logic [NUM_GROUPS*NUM_LANES-1:0]    mac_cs;
   logic [NUM_GROUPS*DATA_WIDTH-1:0]   q_flat;
   logic                               unused_ok;

   assign unused_ok = ^addr_i;
   assign grp_raw   = GW'(addr_i >> (OFS + WA));
`ifdef RAM_ADDR_CHECK_EN
   assign grp_ok = 32'(grp_raw) < NUM_GROUPS;
   assign grp    = grp_raw;
`else
   assign grp_ok = 1'b1;
   assign grp    = GW'(32'(grp_raw) % NUM_GROUPS);
`endif

   assign clearing = state == CLEAR;
   assign gnt_o    = (state == READY) & req_i;
   assign mac_we   = clearing | we_i;
   assign mac_a    = clearing ? clr_cnt : addr_i[OFS +: WA];
   assign mac_d    = clearing ? '0 : wdata_i;

   for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
      for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
         localparam int idx = g * NUM_LANES + k;
         logic [7:0] mem [MACRO_DEPTH];
         assign mac_cs[idx] = clearing | (gnt_o & grp_ok & (grp == GW'(g)) & (~we_i | be_i[k]));
         always_ff @(posedge clk)
            if (mac_cs[idx] && mac_we) mem[mac_a] <= mac_d[k*8 +: 8];
         // TBYPASS routes the macro's D straight to Q
         assign q_flat[g*DATA_WIDTH + k*8 +: 8] = bypass_en_i ? mac_d[k*8 +: 8] : mem[mac_a];
      end
   end

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_GROUPS; i++)
         if (grp == GW'(i)) rd_mux = q_flat[i*DATA_WIDTH +: DATA_WIDTH];
   end

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         state       <= RST;
         clr_cnt     <= '0;
         init_done_o <= 1'b0;
         rvalid_o    <= 1'b0;
         rdata_o     <= '0;
         err_o       <= 1'b0;
      end else begin
         rvalid_o <= gnt_o & ~we_i;
         err_o    <= gnt_o & ~grp_ok;
         if (gnt_o && !we_i) rdata_o <= grp_ok ? rd_mux : '0;
         case (state)
            RST: begin
               state   <= CLEAR;
               clr_cnt <= '0;
            end
            CLEAR: begin
               clr_cnt <= init_i ? '0 : clr_cnt + 1'b1;
               if (!init_i && clr_cnt == WA'(MACRO_DEPTH - 1)) begin
                  state       <= READY;
                  init_done_o <= 1'b1;
               end
            end
            READY: if (init_i) begin
               state       <= CLEAR;
               clr_cnt     <= '0;
               init_done_o <= 1'b0;
            end
            default: state <= RST;
         endcase
      end
   end
endmodule

// File: tb/tb_sp_ram_banked_ctrl.sv
// tb_sp_ram_banked_ctrl: scoreboard bench; second instance (RAM_SIZE=24576) covers out-of-range groups.
module tb_sp_ram_banked_ctrl;
`ifdef RAM_ADDR_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif
   logic clk = 0, rst = 1, req = 0, we = 0, init = 0, bypass = 0;
   logic [14:0] addr = 0;
   logic [3:0]  be = 0;
   logic [31:0] wdata = 0;
   logic gnt, rvalid, init_done, err, gnt2, rvalid2, init_done2, err2;
   logic [31:0] rdata, rdata2;
   int total = 0, bad = 0;
   logic [31:0] sb[$];
   logic [31:0] mdl [int];
   logic pend = 0;

   always #5 clk = ~clk;

   sp_ram_banked_ctrl dut (.clk(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
      .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .init_i(init),
      .init_done_o(init_done), .bypass_en_i(bypass), .err_o(err));

   sp_ram_banked_ctrl #(.RAM_SIZE(24576)) dut2 (.clk(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt2),
      .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid2), .rdata_o(rdata2),
      .init_i(init), .init_done_o(init_done2), .bypass_en_i(bypass), .err_o(err2));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic acc(input logic w, input logic [14:0] a, input logic [3:0] b, input logic [31:0] d);
      @(posedge clk); #1;
      req = 1; we = w; addr = a; be = b; wdata = d;
   endtask

   task automatic idle();
      @(posedge clk); #1;
      req = 0; we = 0;
   endtask

   task automatic measure(input string tag, input int exp_len);
      int n = 0, g = 0;
      @(negedge clk);
      while (!init_done && n < 3000) begin
         n++;
         g += int'(gnt);
         @(negedge clk);
      end
      check({tag, "_len"}, n, exp_len);
      check({tag, "_gnt"}, g, 0);
   endtask

   // scoreboard: model updated on observed grants, expected read data queued
   always @(negedge clk) begin
      logic [31:0] w;
      int k;
      if (rst) begin
         sb.delete();
         mdl.delete();
         pend = 0;
      end else begin
         check("rvalid", rvalid, pend);
         if (rvalid) begin
            if (sb.size() == 0) check("rv_extra", 1, 0);
            else check("rdata", rdata, sb.pop_front());
            check("err", err, 0);
         end
         if (req) check("gnt", gnt, init_done);
         pend = gnt && !we;
         if (gnt) begin
            k = int'(addr >> 2);
            w = mdl.exists(k) ? mdl[k] : 32'h0;
            if (we) begin
               for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = wdata[b*8 +: 8];
               mdl[k] = w;
            end else sb.push_back(w);
         end
         if (init && init_done) mdl.delete();
      end
   end

   initial begin
      req = 1; we = 0; addr = 15'h0000;
      repeat (3) @(posedge clk); #1 rst = 0;
      measure("clr0", 2049);
      acc(0, 15'h7FFC, 4'h0, 0);
      idle();
      acc(1, 15'h0000, 4'hF, 32'hCAFEF00D);
      acc(0, 15'h6000, 4'h0, 0);
      idle();
      @(negedge clk);
      check("d2_rv", rvalid2, 1);
      check("d2_rdata", rdata2, CHK ? 32'h0 : 32'hCAFEF00D);
      check("d2_rerr", err2, CHK);
      acc(1, 15'h6000, 4'hF, 32'h5);
      idle();
      @(negedge clk) check("d2_werr", err2, CHK);
      @(negedge clk) check("d2_werr_off", err2, 0);
      acc(1, 15'h1004, 4'hF, 32'hA5A5A5A5);
      acc(1, 15'h1004, 4'h1, 32'h000000FF);
      acc(0, 15'h1004, 4'h0, 0);
      idle();
      for (int i = 0; i < 4; i++) acc(1, 15'(i * 'h2000), 4'hF, 32'h11111111 * (i + 1));
      for (int i = 0; i < 4; i++) acc(0, 15'(i * 'h2000), 4'h0, 0);
      idle();
      acc(1, 15'h2000, 4'h0, 32'hFFFFFFFF);
      acc(0, 15'h2000, 4'h0, 0);
      acc(1, 15'h3000, 4'b0110, 32'h12345678);
      acc(0, 15'h3000, 4'h0, 0);
      idle();
      acc(1, 15'h1004, 4'hF, 32'hDEADBEEF);
      init = 1;
      @(posedge clk); #1 init = 0; req = 0; we = 0;
      measure("clr_init", 2048);
      acc(0, 15'h0000, 4'h0, 0);
      acc(0, 15'h1004, 4'h0, 0);
      acc(0, 15'h2000, 4'h0, 0);
      acc(0, 15'h3000, 4'h0, 0);
      acc(0, 15'h6000, 4'h0, 0);
      idle();
      @(posedge clk); #1 rst = 1;
      repeat (2) @(posedge clk); #1 rst = 0;
      repeat (1000) @(posedge clk); #1 rst = 1;
      @(posedge clk); #1 rst = 0;
      measure("clr_rst", 2049);
      acc(1, 15'h1000, 4'hF, 32'h5);
      acc(0, 15'h1000, 4'h0, 0);
      @(negedge clk); #2 rst = 1; req = 0;
      @(negedge clk) check("rst_rv", rvalid, 0);
      @(posedge clk); #1 rst = 0;
      measure("clr_rst2", 2049);
      acc(0, 15'h1000, 4'h0, 0);
      idle();
      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
